axi4l_regbank: RTL and testbench
================================

# axi4l_regbank

AXI4-Lite slave register bank that terminates the AXI4-Lite master port of the Wishbone-to-AXI4-Lite bridge. It exposes `NUM_RW_REGS` software-writable control registers to the fabric and `NUM_RO_REGS` hardware-driven status registers to software. AW and W channels are accepted independently. Every access completes with an AXI response so the bridge always receives `bvalid` or `rvalid` and releases its stall.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: register/data width; multiple of 8; byte offset bits `OFFS = $clog2(DATA_WIDTH/8)`.
- `NUM_RW_REGS`, 8: number of read/write registers, ≥1.
- `NUM_RO_REGS`, 4: number of read-only registers, ≥0.
- `RESET_VALUE`, 0: reset value of every RW register.
- `CLK`  in  1  clock; all logic on rising edge.
- `RSTN`  in  1  reset, synchronous, active-low.
- `AXI4LITE_PORT`  axi4l_if.slave  —  AXI4-Lite slave port (aw*, w*, b*, ar*, r*).
- `REGS_OUT`  out  `NUM_RW_REGS*DATA_WIDTH`  RW register contents; reg i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `REGS_IN`  in  `NUM_RO_REGS*DATA_WIDTH`  RO register sources, same packing; sampled at read acceptance.
- `WR_STROBE`  out  `NUM_RW_REGS`  one-cycle pulse on bit i when RW reg i is committed.

## Operation
- Decode: `idx = addr[ADDR_WIDTH-1:OFFS]`.
  - `idx < NUM_RW_REGS`: RW region.
  - `idx < NUM_RW_REGS+NUM_RO_REGS`: RO region.
  - Otherwise: out of range.
  - Low `OFFS` address bits are ignored.
- Write FSM states:
  - `W_IDLE`: awready=1 until AW captured; wready=1 until W captured. Each channel latches on its own handshake and its ready drops once latched. When both are held, next state is `W_COMMIT`.
  - `W_COMMIT`: one cycle, awready=wready=0.
    - RW target: apply the write byte-wise per `wstrb`, assert `WR_STROBE[idx]` (also when `wstrb`=0), bresp=OKAY (2'b00).
    - RO target: no write, bresp=SLVERR (2'b10).
    - Out of range: see Configuration.
    - Set bvalid=1 and go to `W_RESP`.
  - `W_RESP`: hold bvalid and bresp stable until bready=1, then go to `W_IDLE`. awready and wready stay 0.
- Read FSM states:
  - `R_IDLE`: arready=1. On handshake, register rdata and rresp in the same edge, set rvalid=1 and go to `R_RESP`.
    - RW target: rdata = reg, rresp = OKAY.
    - RO target: rdata = `REGS_IN` slice, rresp = OKAY.
  - `R_RESP`: arready=0; hold rvalid, rdata and rresp until rready=1, then go to `R_IDLE`.
- Read and write FSMs are fully independent and may be active in the same cycle.
- Reset values: all RW regs = `RESET_VALUE`; awready=wready=arready=0 during reset; bvalid=rvalid=0, bresp=rresp=0, rdata=0, `WR_STROBE`=0. After reset both FSMs are in IDLE, so readies go to 1 on the first cycle out of reset.
- Reset mid-transaction: the pending transaction is dropped and no write is committed. The master must re-issue it.

## Timing
- AW and W handshakes at edge N (simultaneous or last-of-two): commit at edge N+1. `REGS_OUT`, `WR_STROBE` and bvalid are visible after N+1. Minimum write-to-write period is 3 cycles with bready tied 1.
- AR handshake at edge N: rvalid visible after edge N. Minimum read period is 2 cycles with rready tied 1.
- `WR_STROBE` is high exactly one cycle (the cycle after edge N+1).
- Read and write to the same RW register: the read returns the value before commit if AR is accepted at or before the commit edge N+1.
- AW arriving k cycles before W (or vice versa): the early channel's ready stays low for those k cycles. No second AW is accepted until the response completes.

## Configuration
- `AXI4L_REGBANK_DECERR_EN` defined: out-of-range write has no effect and returns bresp=DECERR (2'b11); out-of-range read returns rdata=0, rresp=DECERR (2'b11).
- Not defined: out-of-range write is silently ignored with bresp=OKAY; out-of-range read returns rdata=0, rresp=OKAY.
- Because the bridge flags errors on resp[1], only the `_EN` build surfaces decode errors to Wishbone.

## Test plan
- Reset, then AW=0x4, W=0xDEADBEEF, wstrb=4'hF in the same cycle: reg1=0xDEADBEEF after 2 edges, `WR_STROBE`=8'h02 for one cycle, bresp=2'b00.
- W (0x000000AA, wstrb=4'h1, reg1 preset 0xDEADBEEF) issued 3 cycles before AW=0x4: wready low after W capture until response; reg1=0xDEADBEAA.
- `REGS_IN` RO reg0 = 0x12345678, NUM_RW_REGS=8, read addr 0x20: rdata=0x12345678, rresp=2'b00. Write to 0x20: no change, bresp=2'b10.
- Read addr 0x100 (out of range): rdata=0. rresp=2'b11 with `AXI4L_REGBANK_DECERR_EN`, 2'b00 without.
- bready held 0 for 5 cycles after a write: bvalid stays 1, awready/wready stay 0, a new AW is not accepted. Concurrent read of reg1 completes normally.
- RSTN pulsed low with AW captured but W not yet: after reset bvalid=0, all RW regs=`RESET_VALUE`, awready=wready=arready=1 on the first cycle out of reset.

Source files
------------

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) shared by the bridge and the register bank.
interface axi4l_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave register bank: NUM_RW_REGS control registers plus NUM_RO_REGS status registers.
// Define AXI4L_REGBANK_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi4l_regbank #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_RW_REGS = 8,
  parameter int unsigned           NUM_RO_REGS = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                                     CLK,
  input  logic                                                     RSTN,
  axi4l_if.slave                                                   AXI4LITE_PORT,
  output logic [NUM_RW_REGS*DATA_WIDTH-1:0]                        REGS_OUT,
  input  logic [(NUM_RO_REGS > 0 ? NUM_RO_REGS*DATA_WIDTH : 1)-1:0] REGS_IN,
  output logic [NUM_RW_REGS-1:0]                                   WR_STROBE
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Offs     = $clog2(NumBytes);
  localparam int unsigned IdxW     = ADDR_WIDTH - Offs;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
`ifdef AXI4L_REGBANK_DECERR_EN
  localparam logic [1:0] RespOor    = 2'b11;
`else
  localparam logic [1:0] RespOor    = 2'b00;
`endif

  typedef enum logic [1:0] {WIdle, WCommit, WResp} wr_state_e;
  typedef enum logic       {RIdle, RResp}          rd_state_e;
  typedef enum logic [1:0] {RegRw, RegRo, RegNone} region_e;

  function automatic region_e decode(input logic [IdxW-1:0] idx);
    if (idx < IdxW'(NUM_RW_REGS)) return RegRw;
    if (idx < IdxW'(NUM_RW_REGS + NUM_RO_REGS)) return RegRo;
    return RegNone;
  endfunction

  logic [IdxW-1:0] ar_idx;
  logic            aw_hs, w_hs, ar_hs;
  logic            unused_addr_lsb;

  assign ar_idx          = AXI4LITE_PORT.araddr[ADDR_WIDTH-1:Offs];
  assign unused_addr_lsb = ^{AXI4LITE_PORT.awaddr[Offs-1:0], AXI4LITE_PORT.araddr[Offs-1:0]};

  // ---------------------------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------------------------
  wr_state_e                        wst_q, wst_d;
  logic                             aw_held_q, aw_held_d;
  logic                             w_held_q, w_held_d;
  logic [IdxW-1:0]                  aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0]            wdata_q, wdata_d;
  logic [NumBytes-1:0]              wstrb_q, wstrb_d;
  logic [NUM_RW_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_RW_REGS-1:0]           wr_strobe_q, wr_strobe_d;
  logic                             bvalid_q, bvalid_d;
  logic [1:0]                       bresp_q, bresp_d;

  // Readies are gated by RSTN so they read 0 for the whole reset interval.
  assign AXI4LITE_PORT.awready = RSTN & (wst_q == WIdle) & ~aw_held_q;
  assign AXI4LITE_PORT.wready  = RSTN & (wst_q == WIdle) & ~w_held_q;
  assign AXI4LITE_PORT.bvalid  = bvalid_q;
  assign AXI4LITE_PORT.bresp   = bresp_q;
  assign aw_hs                 = AXI4LITE_PORT.awvalid & AXI4LITE_PORT.awready;
  assign w_hs                  = AXI4LITE_PORT.wvalid & AXI4LITE_PORT.wready;
  assign REGS_OUT              = regs_q;
  assign WR_STROBE             = wr_strobe_q;

  always_comb begin
    wst_d       = wst_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    aw_idx_d    = aw_idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    regs_d      = regs_q;
    wr_strobe_d = '0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    unique case (wst_q)
      WIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = AXI4LITE_PORT.awaddr[ADDR_WIDTH-1:Offs];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = AXI4LITE_PORT.wdata;
          wstrb_d  = AXI4LITE_PORT.wstrb;
        end
        if (aw_held_d && w_held_d) begin
          wst_d     = WCommit;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      WCommit: begin
        unique case (decode(aw_idx_q))
          RegRw: begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
              if (aw_idx_q == IdxW'(i)) begin
                wr_strobe_d[i] = 1'b1;
                for (int unsigned b = 0; b < NumBytes; b++) begin
                  if (wstrb_q[b]) regs_d[i*DATA_WIDTH + b*8 +: 8] = wdata_q[b*8 +: 8];
                end
              end
            end
            bresp_d = RespOkay;
          end
          RegRo:   bresp_d = RespSlvErr;
          default: bresp_d = RespOor;
        endcase
        bvalid_d = 1'b1;
        wst_d    = WResp;
      end
      WResp: begin
        if (AXI4LITE_PORT.bready) begin
          bvalid_d = 1'b0;
          wst_d    = WIdle;
        end
      end
      default: wst_d = WIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wst_q       <= WIdle;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      regs_q      <= {NUM_RW_REGS{RESET_VALUE}};
      wr_strobe_q <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
    end else begin
      wst_q       <= wst_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      aw_idx_q    <= aw_idx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  rd_state_e             rst_q, rst_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  assign AXI4LITE_PORT.arready = RSTN & (rst_q == RIdle);
  assign AXI4LITE_PORT.rvalid  = rvalid_q;
  assign AXI4LITE_PORT.rdata   = rdata_q;
  assign AXI4LITE_PORT.rresp   = rresp_q;
  assign ar_hs                 = AXI4LITE_PORT.arvalid & AXI4LITE_PORT.arready;

  // RW data comes from regs_q, so a read accepted on the commit edge still sees the old value.
  always_comb begin
    rst_d    = rst_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (rst_q)
      RIdle: begin
        if (ar_hs) begin
          rdata_d = '0;
          rresp_d = RespOor;
          unique case (decode(ar_idx))
            RegRw: begin
              rresp_d = RespOkay;
              for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                if (ar_idx == IdxW'(i)) rdata_d = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
              end
            end
            RegRo: begin
              rresp_d = RespOkay;
              for (int unsigned j = 0; j < NUM_RO_REGS; j++) begin
                if (ar_idx == IdxW'(NUM_RW_REGS + j)) rdata_d = REGS_IN[j*DATA_WIDTH +: DATA_WIDTH];
              end
            end
            default: ;
          endcase
          rvalid_d = 1'b1;
          rst_d    = RResp;
        end
      end
      RResp: begin
        if (AXI4LITE_PORT.rready) begin
          rvalid_d = 1'b0;
          rst_d    = RIdle;
        end
      end
      default: rst_d = RIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rst_q    <= RIdle;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      rst_q    <= rst_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4l_regbank.sv
// Randomized self-checking bench for axi4l_regbank against an array-based register model.
module tb_axi4l_regbank;
  localparam int unsigned NRW = 8;
  localparam int unsigned NRO = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam logic [31:0] RV  = 32'h0000_C0DE;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi4l_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [NRW*DW-1:0] regs_out;
  logic [NRO*DW-1:0] regs_in;
  logic [NRW-1:0]    wr_strobe;

  axi4l_regbank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RW_REGS(NRW), .NUM_RO_REGS(NRO), .RESET_VALUE(RV)
  ) dut (
    .CLK(clk),
    .RSTN(rstn),
    .AXI4LITE_PORT(bus),
    .REGS_OUT(regs_out),
    .REGS_IN(regs_in),
    .WR_STROBE(wr_strobe)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_rw [NRW];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_packed();
    logic [255:0] v = '0;
    for (int i = 0; i < NRW; i++) v[i*32 +: 32] = model_rw[i];
    return v;
  endfunction

  function automatic logic [1:0] oor_resp();
`ifdef AXI4L_REGBANK_DECERR_EN
    return 2'b11;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [1:0] exp_wresp(input int unsigned idx);
    if (idx < NRW) return 2'b00;
    if (idx < NRW + NRO) return 2'b10;
    return oor_resp();
  endfunction

  function automatic logic [1:0] exp_rresp(input int unsigned idx);
    if (idx < NRW + NRO) return 2'b00;
    return oor_resp();
  endfunction

  function automatic logic [31:0] exp_rdata(input int unsigned idx);
    if (idx < NRW) return model_rw[idx];
    if (idx < NRW + NRO) return regs_in[(idx-NRW)*32 +: 32];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned sel = $urandom_range(0, 9);
    int unsigned idx;
    if (sel < 5) idx = $urandom_range(0, NRW-1);
    else if (sel < 8) idx = $urandom_range(NRW, NRW+NRO-1);
    else idx = $urandom_range(NRW+NRO, 255);
    return (idx << 2) | $urandom_range(0, 3);
  endfunction

  // Called at a small offset after a clock edge; returns the same way.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int c = 0;
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int unsigned idx = addr >> 2;
    logic [NRW-1:0] exp_strb = '0;
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    while (!(aw_done && w_done) && c < 40) begin
      bus.awvalid = !aw_done && c >= aw_dly;
      bus.wvalid  = !w_done && c >= w_dly;
      if (aw_done) check_eq("awready_after_capture", bus.awready, 1'b0);
      if (w_done) check_eq("wready_after_capture", bus.wready, 1'b0);
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      aw_done |= hs_aw;
      w_done  |= hs_w;
      c++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check_eq("wr_handshake", {aw_done, w_done}, 2'b11);
    if (!(aw_done && w_done)) return;
    check_eq("bvalid_before_commit", bus.bvalid, 1'b0);
    @(posedge clk); #1;
    if (idx < NRW) begin
      exp_strb[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (strb[b]) model_rw[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    check_eq("wr_strobe", wr_strobe, exp_strb);
    check_eq("regs_out", regs_out, model_packed());
    check_eq("bvalid", bus.bvalid, 1'b1);
    check_eq("bresp", bus.bresp, exp_wresp(idx));
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); #1;
      check_eq("bvalid_stall", bus.bvalid, 1'b1);
      check_eq("bresp_stall", bus.bresp, exp_wresp(idx));
      check_eq("aw_w_ready_stall", {bus.awready, bus.wready}, 2'b00);
      if (k == 0) check_eq("wr_strobe_pulse", wr_strobe, '0);
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check_eq("bvalid_cleared", bus.bvalid, 1'b0);
    if (b_dly == 0) check_eq("wr_strobe_pulse", wr_strobe, '0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    int c = 0;
    bit done = 0;
    logic [31:0] e_data;
    logic [1:0]  e_resp;
    int unsigned idx = addr >> 2;
    repeat (ar_dly) begin @(posedge clk); #1; end
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!done && c < 40) begin
      if (bus.arready) begin
        // Model writes land 1 unit after an edge; snapshot after them, before the accept edge.
        #1;
        e_data = exp_rdata(idx);
        e_resp = exp_rresp(idx);
        done   = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    bus.arvalid = 1'b0;
    check_eq("rd_handshake", done, 1'b1);
    if (!done) return;
    check_eq("rvalid", bus.rvalid, 1'b1);
    check_eq("rdata", bus.rdata, e_data);
    check_eq("rresp", bus.rresp, e_resp);
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk); #1;
      check_eq("rdata_stall", {bus.rvalid, bus.rdata}, {1'b1, e_data});
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check_eq("rvalid_cleared", bus.rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1, a2, d;
    logic [3:0]  s;
    int          op, c;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    regs_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < NRW; i++) model_rw[i] = RV;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check_eq("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    check_eq("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, '0);
    check_eq("rst_regs", regs_out, model_packed());
    check_eq("rst_strobe", wr_strobe, '0);
    rstn = 1'b1;
    #1;
    check_eq("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(posedge clk); #1;

    // Simultaneous AW/W full-word write to reg1
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check_eq("tp1_reg1", regs_out[63:32], 32'hDEADBEEF);
    // W three cycles ahead of AW, single byte lane
    axi_write(32'h4, 32'h0000_00AA, 4'h1, 3, 0, 0);
    check_eq("tp2_reg1", regs_out[63:32], 32'hDEADBEAA);
    // AW ahead of W, zero strobe still pulses WR_STROBE
    axi_write(32'h8, 32'hFFFF_FFFF, 4'h0, 0, 2, 1);
    // RO region read and rejected write
    regs_in[31:0] = 32'h1234_5678;
    axi_read(32'h20, 0, 0);
    axi_write(32'h20, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    // Out of range
    axi_read(32'h100, 0, 1);
    axi_write(32'h100, 32'h1111_2222, 4'hF, 0, 0, 0);
    // Response stall with a concurrent read of reg1
    fork
      axi_write(32'h4, 32'h5A5A_0001, 4'hF, 0, 0, 5);
      begin
        repeat (3) @(posedge clk);
        #1;
        axi_read(32'h4, 0, 0);
      end
    join

    // Reset with AW captured but W pending
    bus.awaddr  = 32'hC;
    bus.awvalid = 1'b1;
    c = 0;
    while (!bus.awready && c < 10) begin @(posedge clk); #1; c++; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    check_eq("mid_awready_low", bus.awready, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    rstn = 1'b1;
    #1;
    for (int i = 0; i < NRW; i++) model_rw[i] = RV;
    check_eq("mid_post_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check_eq("mid_post_bvalid", bus.bvalid, 1'b0);
    check_eq("mid_post_regs", regs_out, model_packed());
    check_eq("mid_post_strobe", wr_strobe, '0);
    @(posedge clk); #1;
    axi_write(32'hC, 32'h0BAD_F00D, 4'h6, 1, 0, 0);

    // Randomized mix of writes, reads and overlapping write/read pairs
    for (int it = 0; it < 80; it++) begin
      a1 = rand_addr();
      a2 = rand_addr();
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) regs_in = {$urandom, $urandom, $urandom, $urandom};
      if (op == 0) begin
        axi_write(a1, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (op == 1) begin
        axi_read(a1, 0, $urandom_range(0, 2));
      end else begin
        fork
          axi_write(a1, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
          axi_read(a2, $urandom_range(0, 4), $urandom_range(0, 2));
        join
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
